// File: rtl/poly_compress_pack.sv
// rtl/poly_compress_pack.sv - Kyber512 Bp/V compress and bit-pack into 64-bit ciphertext words
// Optional POLY_COMPRESS_RANGE_CHECK_EN adds sticky Coeff_range_err output.
module poly_compress_pack #(
  parameter int KYBER_Q           = 3329,
  parameter int KYBER_DU          = 10,
  parameter int KYBER_DV          = 4,
  parameter int i_Sub_BRAM_Length = 128,
  parameter int o_Ct_Length       = 64,
  parameter int Bp_Words          = 64,
  parameter int Total_Words       = 96
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  output logic [7:0]                   Sub_RAd,
  input  logic [i_Sub_BRAM_Length-1:0] Sub_RData,
  output logic [6:0]                   Ct_WAd,
  output logic [o_Ct_Length-1:0]       Ct_WData,
  output logic                         Ct_outready,
  output logic                         Function_done
`ifdef POLY_COMPRESS_RANGE_CHECK_EN
  ,
  output logic                         Coeff_range_err
`endif
);

  localparam int ACC_W  = 144;
  // ceil(2^34 / 3329): floor(n * QINV >> 34) == floor(n / 3329) for every numerator we can see
  localparam int QINV   = 5160670;
  localparam int QSHIFT = 34;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_EMIT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ACC_W-1:0]      acc;
  logic [7:0]            cnt;
  logic [6:0]            wr_ptr;
  logic                  is_bp;
  logic                  last_word;
  logic                  emit_now;
  logic [8*KYBER_DU-1:0] pack_bp;
  logic [8*KYBER_DV-1:0] pack_v;
  logic [7:0]            ge_q;
  logic [ACC_W-1:0]      load_bits;
  logic [7:0]            load_cnt;

  assign is_bp     = Sub_RAd < 8'(Bp_Words);
  assign last_word = Sub_RAd == 8'(Total_Words - 1);

  // Both field widths share one divider per lane; only the numerator shift differs.
  for (genvar j = 0; j < 8; j++) begin : g_coeff
    logic [15:0] c_raw;
    logic [15:0] c_sub;
    logic [11:0] c_red;
    logic [21:0] num;
    logic [44:0] prod;
    logic [10:0] quo;
    logic        unused_coeff;

    assign c_raw   = Sub_RData[16*j +: 16];
    assign c_sub   = c_raw - 16'(KYBER_Q);
    assign ge_q[j] = c_raw >= 16'(KYBER_Q);
    assign c_red   = ge_q[j] ? c_sub[11:0] : c_raw[11:0];
    assign num     = is_bp ? ((22'(c_red) << KYBER_DU) + 22'd1664)
                           : ((22'(c_red) << KYBER_DV) + 22'd1664);
    assign prod    = 45'(num) * 45'(QINV);
    assign quo     = prod[44:QSHIFT];
    assign pack_bp[KYBER_DU*j +: KYBER_DU] = quo[KYBER_DU-1:0];
    assign pack_v[KYBER_DV*j +: KYBER_DV]  = quo[KYBER_DV-1:0];
    assign unused_coeff = ^{c_sub[15:12], prod[QSHIFT-1:0], quo[10]};
  end

  assign load_bits = is_bp ? ACC_W'(pack_bp) : ACC_W'(pack_v);
  assign load_cnt  = is_bp ? 8'(8*KYBER_DU) : 8'(8*KYBER_DV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (enable) state_nxt = S_READ;
      S_READ: state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_EMIT;
      S_EMIT: if (cnt < 8'(o_Ct_Length)) state_nxt = last_word ? S_DONE : S_READ;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    emit_now      = (state == S_EMIT) && (cnt >= 8'(o_Ct_Length));
    Function_done = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Sub_RAd     <= '0;
      Ct_WAd      <= '0;
      Ct_WData    <= '0;
      Ct_outready <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      wr_ptr      <= '0;
    end else begin
      Ct_outready <= emit_now;
      case (state)
        S_IDLE: begin
          if (enable) begin
            Sub_RAd <= '0;
            acc     <= '0;
            cnt     <= '0;
            wr_ptr  <= '0;
          end
        end
        S_LOAD: begin
          acc <= acc | (load_bits << cnt);
          cnt <= cnt + load_cnt;
        end
        S_EMIT: begin
          if (emit_now) begin
            Ct_WData <= acc[o_Ct_Length-1:0];
            Ct_WAd   <= wr_ptr;
            wr_ptr   <= wr_ptr + 7'd1;
            acc      <= acc >> o_Ct_Length;
            cnt      <= cnt - 8'(o_Ct_Length);
          end else if (!last_word) begin
            Sub_RAd <= Sub_RAd + 8'd1;
          end
        end
        S_DONE: begin
          Sub_RAd <= '0;
          Ct_WAd  <= '0;
          wr_ptr  <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef POLY_COMPRESS_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               Coeff_range_err <= 1'b0;
    else if (state == S_IDLE && enable)    Coeff_range_err <= 1'b0;
    else if (state == S_LOAD && (|ge_q))   Coeff_range_err <= 1'b1;
  end
`else
  logic unused_range;
  assign unused_range = ^ge_q;
`endif

endmodule

// File: tb/tb_poly_compress_pack.sv
// tb/tb_poly_compress_pack.sv - self-checking bench for poly_compress_pack against a bit-stream model
module tb_poly_compress_pack;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [7:0]   Sub_RAd;
  logic [127:0] Sub_RData;
  logic [6:0]   Ct_WAd;
  logic [63:0]  Ct_WData;
  logic         Ct_outready;
  logic         Function_done;
`ifdef POLY_COMPRESS_RANGE_CHECK_EN
  logic         Coeff_range_err;
`endif

  poly_compress_pack dut (
    .clk(clk), .rst(rst), .enable(enable),
    .Sub_RAd(Sub_RAd), .Sub_RData(Sub_RData),
    .Ct_WAd(Ct_WAd), .Ct_WData(Ct_WData),
    .Ct_outready(Ct_outready), .Function_done(Function_done)
`ifdef POLY_COMPRESS_RANGE_CHECK_EN
    , .Coeff_range_err(Coeff_range_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:255][0:7];
  logic [63:0] exp_ct [0:95];
  logic [6:0]  wa_q [$];
  logic [63:0] wd_q [$];
  int          done_cnt;

  // one-cycle-latency source BRAM
  always @(posedge clk)
    for (int j = 0; j < 8; j++) Sub_RData[16*j +: 16] <= mem[Sub_RAd][j];

  always @(negedge clk) begin
    if (Ct_outready) begin
      wa_q.push_back(Ct_WAd);
      wd_q.push_back(Ct_WData);
    end
    if (Function_done) done_cnt++;
  end

  function automatic int comp(input int c_in, input int d);
    int c;
    c = c_in;
    if (c >= 3329) c = c - 3329;
    return (((c * (1 << d)) + 1664) / 3329) % (1 << d);
  endfunction

  task automatic build_expected();
    bit s [0:6143];
    int pos, t, d;
    pos = 0;
    for (int w = 0; w < 96; w++)
      for (int j = 0; j < 8; j++) begin
        d = (w < 64) ? 10 : 4;
        t = comp(int'(mem[w][j]), d);
        for (int b = 0; b < d; b++) s[pos + b] = t[b];
        pos += d;
      end
    for (int n = 0; n < 96; n++)
      for (int b = 0; b < 64; b++) exp_ct[n][b] = s[64*n + b];
  endtask

  task automatic fill_const(input int v);
    for (int w = 0; w < 256; w++)
      for (int j = 0; j < 8; j++) mem[w][j] = 16'(v);
  endtask

  task automatic do_run(input int extra_en, output bit to);
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    build_expected();
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    to = 1'b1;
    for (int i = 1; i < 3000; i++) begin
      if (Function_done) begin
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
      enable = (i == extra_en);
    end
    enable = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    fill_const(0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (Sub_RAd !== 8'd0)      begin errors++; $display("FAIL reset_rad got %0d want 0", Sub_RAd); end
    checks++; if (Ct_WAd !== 7'd0)       begin errors++; $display("FAIL reset_wad got %0d want 0", Ct_WAd); end
    checks++; if (Ct_WData !== 64'd0)    begin errors++; $display("FAIL reset_wdata got %h want 0", Ct_WData); end
    checks++; if (Ct_outready !== 1'b0)  begin errors++; $display("FAIL reset_ready got %b want 0", Ct_outready); end
    checks++; if (Function_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Function_done); end
`ifdef POLY_COMPRESS_RANGE_CHECK_EN
    checks++; if (Coeff_range_err !== 1'b0) begin errors++; $display("FAIL reset_rerr got %b want 0", Coeff_range_err); end
`endif
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_zero();
    bit to;
    fill_const(0);
    do_run(-1, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL zero_timeout got %b want 0", to); end
    checks++; if (wa_q.size() !== 96) begin errors++; $display("FAIL zero_count got %0d want 96", wa_q.size()); end
    for (int n = 0; n < 96 && n < wa_q.size(); n++) begin
      checks++;
      if (wa_q[n] !== 7'(n) || wd_q[n] !== 64'd0)
        begin errors++; $display("FAIL zero_word%0d got %0d:%h want %0d:0", n, wa_q[n], wd_q[n], n); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done got %0d want 1", done_cnt); end
`ifdef POLY_COMPRESS_RANGE_CHECK_EN
    checks++; if (Coeff_range_err !== 1'b0) begin errors++; $display("FAIL zero_rerr got %b want 0", Coeff_range_err); end
`endif
  endtask

  task automatic test_const_patterns();
    bit to;
    int vals [3] = '{1664, 3328, 832};
    for (int p = 0; p < 3; p++) begin
      fill_const(vals[p]);
      do_run(-1, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL const%0d_timeout got %b want 0", vals[p], to); end
      checks++; if (wa_q.size() !== 96) begin errors++; $display("FAIL const%0d_count got %0d want 96", vals[p], wa_q.size()); end
      for (int n = 0; n < 96 && n < wa_q.size(); n++) begin
        checks++;
        if (wa_q[n] !== 7'(n) || wd_q[n] !== exp_ct[n])
          begin errors++; $display("FAIL const%0d_word%0d got %0d:%h want %0d:%h", vals[p], n, wa_q[n], wd_q[n], n, exp_ct[n]); end
      end
      if (wd_q.size() == 96) begin
        checks++;
        if (vals[p] == 1664 && wd_q[80] !== 64'h8888888888888888)
          begin errors++; $display("FAIL v1664_word80 got %h want 8888888888888888", wd_q[80]); end
        checks++;
        if (vals[p] == 3328 && wd_q[10] !== 64'd0)
          begin errors++; $display("FAIL wrap3328_word10 got %h want 0", wd_q[10]); end
        checks++;
        if (vals[p] == 832 && wd_q[95] !== 64'h4444444444444444)
          begin errors++; $display("FAIL v832_word95 got %h want 4444444444444444", wd_q[95]); end
      end
    end
  endtask

  task automatic test_random();
    bit to;
    fill_const(0);
    for (int j = 0; j < 8; j++) mem[0][j] = 16'(j + 1);
    do_run(-1, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL seq_timeout got %b want 0", to); end
    for (int n = 0; n < 2 && n < wd_q.size(); n++) begin
      checks++;
      if (wd_q[n] !== exp_ct[n]) begin errors++; $display("FAIL seq_word%0d got %h want %h", n, wd_q[n], exp_ct[n]); end
    end
    for (int w = 0; w < 96; w++)
      for (int j = 0; j < 8; j++) mem[w][j] = 16'($urandom_range(0, 6657));
    do_run(-1, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL rand_timeout got %b want 0", to); end
    checks++; if (wa_q.size() !== 96) begin errors++; $display("FAIL rand_count got %0d want 96", wa_q.size()); end
    for (int n = 0; n < 96 && n < wa_q.size(); n++) begin
      checks++;
      if (wa_q[n] !== 7'(n) || wd_q[n] !== exp_ct[n])
        begin errors++; $display("FAIL rand_word%0d got %0d:%h want %0d:%h", n, wa_q[n], wd_q[n], n, exp_ct[n]); end
    end
  endtask

  task automatic test_mid_enable();
    bit to;
    int n_end;
    for (int w = 0; w < 96; w++)
      for (int j = 0; j < 8; j++) mem[w][j] = 16'($urandom_range(0, 3328));
    mem[70][3] = 16'd3400;
    do_run(100, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL mid_timeout got %b want 0", to); end
    checks++; if (wa_q.size() !== 96) begin errors++; $display("FAIL mid_count got %0d want 96", wa_q.size()); end
    for (int n = 0; n < 96 && n < wa_q.size(); n++) begin
      checks++;
      if (wa_q[n] !== 7'(n) || wd_q[n] !== exp_ct[n])
        begin errors++; $display("FAIL mid_word%0d got %0d:%h want %0d:%h", n, wa_q[n], wd_q[n], n, exp_ct[n]); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL mid_done got %0d want 1", done_cnt); end
`ifdef POLY_COMPRESS_RANGE_CHECK_EN
    checks++; if (Coeff_range_err !== 1'b1) begin errors++; $display("FAIL mid_rerr got %b want 1", Coeff_range_err); end
`endif
    n_end = wa_q.size();
    repeat (100) @(posedge clk);
    #1;
    checks++; if (wa_q.size() !== n_end) begin errors++; $display("FAIL idle_quiet got %0d want %0d", wa_q.size(), n_end); end
    checks++; if (Ct_WData !== exp_ct[95]) begin errors++; $display("FAIL hold_wdata got %h want %h", Ct_WData, exp_ct[95]); end
    checks++; if (Ct_outready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b want 0", Ct_outready); end
  endtask

  task automatic test_abort();
    bit to, hit;
    int n_at;
    for (int w = 0; w < 96; w++)
      for (int j = 0; j < 8; j++) mem[w][j] = 16'($urandom_range(0, 3328));
    wa_q.delete(); wd_q.delete(); done_cnt = 0;
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(posedge clk); #1;
      if (Ct_outready && Ct_WAd == 7'd39) hit = 1'b1;
    end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL abort_reach40 got %b want 1", hit); end
    rst = 1'b1;
    #1;
    n_at = wa_q.size();
    checks++; if (Ct_outready !== 1'b0) begin errors++; $display("FAIL abort_ready got %b want 0", Ct_outready); end
    checks++; if (Ct_WAd !== 7'd0 || Ct_WData !== 64'd0 || Sub_RAd !== 8'd0)
      begin errors++; $display("FAIL abort_outs got %0d:%h:%0d want 0:0:0", Ct_WAd, Ct_WData, Sub_RAd); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    checks++; if (wa_q.size() !== n_at || done_cnt !== 0)
      begin errors++; $display("FAIL abort_quiet got %0d/%0d want %0d/0", wa_q.size(), done_cnt, n_at); end
    do_run(-1, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL rerun_timeout got %b want 0", to); end
    checks++; if (wa_q.size() !== 96) begin errors++; $display("FAIL rerun_count got %0d want 96", wa_q.size()); end
    for (int n = 0; n < 96 && n < wa_q.size(); n++) begin
      checks++;
      if (wa_q[n] !== 7'(n) || wd_q[n] !== exp_ct[n])
        begin errors++; $display("FAIL rerun_word%0d got %0d:%h want %0d:%h", n, wa_q[n], wd_q[n], n, exp_ct[n]); end
    end
  endtask

  task automatic test_sweep();
    bit to;
    int bad;
    for (int r = 0; r < 13; r++) begin
      for (int w = 0; w < 64; w++)
        for (int j = 0; j < 8; j++) mem[w][j] = 16'((r*512 + w*8 + j) % 3329);
      for (int w = 64; w < 96; w++)
        for (int j = 0; j < 8; j++) mem[w][j] = 16'((r*256 + (w-64)*8 + j) % 3329);
      do_run(-1, to);
      bad = 0;
      checks++;
      if (to !== 1'b0 || wa_q.size() !== 96) begin
        errors++;
        $display("FAIL sweep%0d_run got to=%b n=%0d want to=0 n=96", r, to, wa_q.size());
      end
      for (int n = 0; n < 96 && n < wa_q.size(); n++) begin
        checks++;
        if (wd_q[n] !== exp_ct[n])
          begin errors++; $display("FAIL sweep%0d_word%0d got %h want %h", r, n, wd_q[n], exp_ct[n]); end
      end
    end
`ifdef POLY_COMPRESS_RANGE_CHECK_EN
    checks++; if (Coeff_range_err !== 1'b0) begin errors++; $display("FAIL sweep_rerr got %b want 0", Coeff_range_err); end
`endif
  endtask

  initial begin
    test_reset();
    test_zero();
    test_const_patterns();
    test_random();
    test_mid_enable();
    test_abort();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
